// File: rtl/ntt_pkg.sv
// Shared constants for the NTT stream framer: FSM encoding, command tag and frame lengths.
package ntt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_CMD       = 2'd1;
  localparam state_t ST_DATA      = 2'd2;
  localparam state_t ST_WAIT_DONE = 2'd3;

  localparam logic [1:0] CMD_TAG = 2'b01;

  localparam int FRAME_LEN_U = 1024;
  localparam int FRAME_LEN_F = 2048;

  // mode bit 1 selects the short frame
  function automatic int frame_len(input logic mode_hi);
    return mode_hi ? FRAME_LEN_U : FRAME_LEN_F;
  endfunction

endpackage

// File: rtl/ntt_stream_framer_if.sv
// Stream bundle between coefficient source, framer and NTT engine.
// The framer takes the master modport; the environment takes slave.
interface ntt_stream_framer_if #(
  parameter int pDATA_WIDTH = 32
);

  logic                   s_tvalid;
  logic                   s_tready;
  logic [pDATA_WIDTH-1:0] s_tdata;

  logic                   m_tvalid;
  logic                   m_tready;
  logic [pDATA_WIDTH-1:0] m_tdata;
  logic                   m_tlast;

  modport master (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/ntt_stream_framer.sv
// Frames a raw coefficient stream for the NTT engine: one command beat, then N data beats with tlast.
// Optional running XOR of the data beats on port chksum when NTT_FRAMER_CHKSUM_EN is defined.
module ntt_stream_framer
  import ntt_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pCNT_WIDTH  = 12
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  cfg_start,
  input  logic [1:0]            cfg_mode,
  input  logic                  dn_done,
  ntt_stream_framer_if.master   axis,
  output logic                  busy,
  output logic                  frame_done,
  output logic [pCNT_WIDTH-1:0] beat_cnt
`ifdef NTT_FRAMER_CHKSUM_EN
  ,
  output logic [pDATA_WIDTH-1:0] chksum
`endif
);

  // beat_cnt must reach FRAME_LEN_F without wrapping, so pCNT_WIDTH >= 12
  localparam logic [pCNT_WIDTH-1:0] LAST_U = pCNT_WIDTH'(frame_len(1'b1) - 1);
  localparam logic [pCNT_WIDTH-1:0] LAST_F = pCNT_WIDTH'(frame_len(1'b0) - 1);

  state_t                  state_reg;
  state_t                  state_next;
  logic [1:0]              mode_reg;
  logic [1:0]              mode_next;
  logic [pCNT_WIDTH-1:0]   beat_cnt_reg;
  logic [pCNT_WIDTH-1:0]   beat_cnt_next;
  logic                    frame_done_reg;
  logic                    frame_done_next;

  logic [pCNT_WIDTH-1:0]   last_idx;
  logic                    last_beat;
  logic                    beat_fire;
  logic                    frame_start;
  logic [pDATA_WIDTH-1:0]  cmd_word;

  assign last_idx    = mode_reg[1] ? LAST_U : LAST_F;
  assign last_beat   = (beat_cnt_reg == last_idx);
  assign beat_fire   = (state_reg == ST_DATA) && axis.s_tvalid && axis.m_tready;
  assign frame_start = (state_reg == ST_IDLE) && cfg_start;

  // Built only from registered mode, so it is stable across a CMD stall
  always_comb begin
    cmd_word      = '0;
    cmd_word[3:0] = {CMD_TAG, mode_reg};
  end

  always_comb begin
    axis.m_tvalid = 1'b0;
    axis.m_tdata  = '0;
    axis.m_tlast  = 1'b0;
    axis.s_tready = 1'b0;
    case (state_reg)
      ST_CMD: begin
        axis.m_tvalid = 1'b1;
        axis.m_tdata  = cmd_word;
      end
      ST_DATA: begin
        axis.m_tvalid = axis.s_tvalid;
        axis.m_tdata  = axis.s_tdata;
        axis.s_tready = axis.m_tready;
        axis.m_tlast  = last_beat;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    beat_cnt_next   = beat_cnt_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          mode_next     = cfg_mode;
          beat_cnt_next = '0;
          state_next    = ST_CMD;
        end
      end
      ST_CMD: begin
        if (axis.m_tready) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_fire) begin
          beat_cnt_next = beat_cnt_reg + pCNT_WIDTH'(1);
          if (last_beat) begin
            state_next = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (dn_done) begin
          frame_done_next = 1'b1;
          state_next      = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= '0;
      beat_cnt_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      beat_cnt_reg   <= beat_cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = frame_done_reg;
  assign beat_cnt   = beat_cnt_reg;

`ifdef NTT_FRAMER_CHKSUM_EN
  logic [pDATA_WIDTH-1:0] chksum_reg;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      chksum_reg <= '0;
    end else if (frame_start) begin
      chksum_reg <= '0;
    end else if (beat_fire) begin
      chksum_reg <= chksum_reg ^ axis.s_tdata;
    end
  end

  assign chksum = chksum_reg;
`else
  logic unused_ok;
  assign unused_ok = frame_start;
`endif

endmodule

// File: tb/tb_ntt_stream_framer.sv
// Directed bench for ntt_stream_framer: full/short frames, stalls, ignored start/done, mid-frame reset.
module tb_ntt_stream_framer;

  localparam int DW = 32;
  localparam int CW = 12;

  logic          axi_clk     = 1'b0;
  logic          axi_reset_n = 1'b1;
  logic          cfg_start   = 1'b0;
  logic [1:0]    cfg_mode    = 2'd0;
  logic          dn_done     = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] beat_cnt;
`ifdef NTT_FRAMER_CHKSUM_EN
  logic [DW-1:0] chksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ntt_stream_framer_if #(.pDATA_WIDTH(DW)) axis();

  ntt_stream_framer #(
    .pDATA_WIDTH(DW),
    .pCNT_WIDTH (CW)
  ) dut (
    .axi_clk    (axi_clk),
    .axi_reset_n(axi_reset_n),
    .cfg_start  (cfg_start),
    .cfg_mode   (cfg_mode),
    .dn_done    (dn_done),
    .axis       (axis),
    .busy       (busy),
    .frame_done (frame_done),
    .beat_cnt   (beat_cnt)
`ifdef NTT_FRAMER_CHKSUM_EN
    ,
    .chksum     (chksum)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mvalid"}, 64'(axis.m_tvalid), 64'd0);
    check({tag, "_sready"}, 64'(axis.s_tready), 64'd0);
    check({tag, "_mlast"},  64'(axis.m_tlast),  64'd0);
  endtask

  // One complete frame. start_at/done_at inject a stray cfg_start/dn_done while
  // the given beat is pending; reset_at pulls reset with that beat pending.
  task automatic run_frame(input logic [1:0] mode, input logic [31:0] data_base, input bit stall,
                           input int start_at, input int done_at, input int reset_at);
    int          n_exp;
    int          idx;
    int          cyc;
    int          cmd_cyc;
    logic [31:0] cmd_exp;
    logic [31:0] x_exp;
    logic [31:0] d;

    n_exp   = mode[1] ? 1024 : 2048;
    cmd_exp = 32'h4 | {30'd0, mode};
    x_exp   = 32'd0;

    cfg_mode      = mode;
    cfg_start     = 1'b1;
    axis.s_tvalid = 1'b0;
    axis.m_tready = 1'b0;
    tick();
    cfg_start = 1'b0;
    cfg_mode  = ~mode;
    check("start_cnt", 64'(beat_cnt), 64'd0);

    cmd_cyc = 0;
    forever begin
      axis.m_tready = stall ? ((cmd_cyc >= 3) && ($urandom_range(1, 0) == 1)) : 1'b1;
      axis.s_tvalid = 1'b1;
      axis.s_tdata  = 32'hDEAD_BEEF;
      #1;
      check("cmd_valid",  64'(axis.m_tvalid), 64'd1);
      check("cmd_data",   64'(axis.m_tdata),  64'(cmd_exp));
      check("cmd_last",   64'(axis.m_tlast),  64'd0);
      check("cmd_sready", 64'(axis.s_tready), 64'd0);
      check("cmd_busy",   64'(busy),          64'd1);
      tick();
      cmd_cyc++;
      if (axis.m_tready) break;
      if (cmd_cyc > 60) begin
        check("cmd_timeout", 64'(cmd_cyc), 64'd0);
        break;
      end
    end

    idx = 0;
    cyc = 0;
    while (idx < n_exp && cyc < 20000) begin
      d             = data_base + 32'(idx);
      axis.s_tvalid = stall ? ($urandom_range(3, 0) != 0) : 1'b1;
      axis.m_tready = stall ? ($urandom_range(3, 0) != 0) : 1'b1;
      axis.s_tdata  = axis.s_tvalid ? d : (32'hBAD0_0000 ^ d);
      cfg_start     = (idx == start_at);
      dn_done       = (idx == done_at);
      #1;
      if (idx == reset_at) begin
        axi_reset_n = 1'b0;
        #1;
        check_quiet("rst");
        check("rst_mdata", 64'(axis.m_tdata), 64'd0);
        check("rst_busy",  64'(busy),         64'd0);
        check("rst_cnt",   64'(beat_cnt),     64'd0);
        check("rst_fdone", 64'(frame_done),   64'd0);
`ifdef NTT_FRAMER_CHKSUM_EN
        check("rst_chksum", 64'(chksum), 64'd0);
`endif
        cfg_start = 1'b0;
        dn_done   = 1'b0;
        tick();
        axi_reset_n = 1'b1;
        tick();
        check("rst_idle_busy", 64'(busy), 64'd0);
        check_quiet("rst_idle");
        $display("frame mode=%0d aborted by reset at beat %0d", mode, idx);
        return;
      end
      check("d_valid",  64'(axis.m_tvalid), 64'(axis.s_tvalid));
      if (axis.s_tvalid) check("d_data", 64'(axis.m_tdata), 64'(d));
      check("d_sready", 64'(axis.s_tready), 64'(axis.m_tready));
      check("d_last",   64'(axis.m_tlast),  64'(idx == n_exp - 1));
      check("d_cnt",    64'(beat_cnt),      64'(idx));
      if (axis.s_tvalid && axis.m_tready) begin
        x_exp ^= d;
        idx++;
      end
      tick();
      cyc++;
    end
    cfg_start = 1'b0;
    dn_done   = 1'b0;
    if (idx != n_exp) check("data_timeout", 64'(idx), 64'(n_exp));

    for (int w = 0; w < 2; w++) begin
      axis.s_tvalid = 1'b1;
      axis.m_tready = 1'b1;
      #1;
      check_quiet("wait");
      check("wait_busy",  64'(busy),       64'd1);
      check("wait_cnt",   64'(beat_cnt),   64'(n_exp));
      check("wait_fdone", 64'(frame_done), 64'd0);
`ifdef NTT_FRAMER_CHKSUM_EN
      check("wait_chksum", 64'(chksum), 64'(x_exp));
`endif
      tick();
    end

    dn_done = 1'b1;
    tick();
    dn_done = 1'b0;
    check("done_pulse", 64'(frame_done), 64'd1);
    check("done_busy",  64'(busy),       64'd0);
    check_quiet("done");
    tick();
    check("done_single", 64'(frame_done), 64'd0);
    check("hold_cnt",    64'(beat_cnt),   64'(n_exp));
`ifdef NTT_FRAMER_CHKSUM_EN
    check("hold_chksum", 64'(chksum), 64'(x_exp));
`endif
    $display("frame mode=%0d beats=%0d base=0x%0h stall=%0d checks=%0d", mode, idx, data_base, stall, n_checks);
  endtask

  initial begin
    axis.s_tvalid = 1'b0;
    axis.s_tdata  = '0;
    axis.m_tready = 1'b0;
    #2 axi_reset_n = 1'b0;
    tick();
    tick();
    check("reset_busy",  64'(busy),         64'd0);
    check("reset_cnt",   64'(beat_cnt),     64'd0);
    check("reset_fdone", 64'(frame_done),   64'd0);
    check("reset_mdata", 64'(axis.m_tdata), 64'd0);
    check_quiet("reset");
    axi_reset_n = 1'b1;
    tick();

    // Idle: source and sink active but nothing passes; stray dn_done dropped
    axis.s_tvalid = 1'b1;
    axis.m_tready = 1'b1;
    dn_done       = 1'b1;
    #1;
    check_quiet("idle");
    tick();
    dn_done = 1'b0;
    check("idle_done_drop", 64'(frame_done), 64'd0);
    check("idle_busy",      64'(busy),       64'd0);
    $display("idle check with stray dn_done");

    run_frame(2'd0, 32'd1,          1'b0, -1,  -1,  -1);
    run_frame(2'd3, 32'h0000_1000,  1'b0, -1,  -1,  -1);
    run_frame(2'd2, 32'h5000_0000,  1'b1, -1,  -1,  -1);
    run_frame(2'd1, 32'hA000_0000,  1'b0, 100, 300, -1);
    run_frame(2'd0, 32'd1,          1'b0, -1,  -1,  500);
    run_frame(2'd0, 32'd1,          1'b0, -1,  -1,  -1);
`ifdef NTT_FRAMER_CHKSUM_EN
    check("chksum_1_to_2048", 64'(chksum), 64'h0000_0800);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
